// File: rtl/serial_word_loader_pkg.sv
// Package for serial_word_loader.
// Provides the FSM state type, built on the shared state encodings.
`include "fsm_state_codes.sv"

package serial_word_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = `FSM_ST_IDLE,
    ST_SHIFT = `FSM_ST_SHIFT,
    ST_DONE  = `FSM_ST_DONE
  } swl_state_t;

endpackage

// File: rtl/fsm_state_codes.sv
// Shared FSM state encodings for the small control FSMs in this codebase.
// This file holds only include-guarded macros. Any package or module that
// needs a common state code includes it.
`ifndef FSM_STATE_CODES_SV
`define FSM_STATE_CODES_SV

`define FSM_ST_IDLE  2'd0
`define FSM_ST_SHIFT 2'd1
`define FSM_ST_DONE  2'd2

`endif

// File: rtl/serial_word_loader_shift_counter.sv
// shift_counter: serial-in shift register plus a count of the accepted bits.
// Ports:
//   CLK, RST    clock; asynchronous active-high reset
//   i_clear     discard the partial word and zero the count (has priority)
//   i_shift     shift i_sin in and increment the count
//   i_sin       serial data bit
//   o_shifted   the register value as it would be after shifting i_sin in
//               (combinational); the parent captures the completed word here
//   o_bitcnt    number of bits accepted so far
module shift_counter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_clear,
  input  logic                   i_shift,
  input  logic                   i_sin,
  output logic [WIDTH-1:0]       o_shifted,
  output logic [$clog2(WIDTH):0] o_bitcnt
);

  logic [WIDTH-1:0]       r_sreg;
  logic [$clog2(WIDTH):0] r_cnt;
  logic [WIDTH-1:0]       w_shifted;

  // MSB-first: data enters at bit 0, so after WIDTH shifts the first bit sits at the MSB.
  // LSB-first: data enters at the MSB, so after WIDTH shifts the first bit sits at bit 0.
  always_comb begin
    if (MSB_FIRST) w_shifted = {r_sreg[WIDTH-2:0], i_sin};
    else           w_shifted = {i_sin, r_sreg[WIDTH-1:1]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_sreg <= w_shifted;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_shifted = w_shifted;
  assign o_bitcnt  = r_cnt;

endmodule

// File: rtl/serial_word_loader.sv
// serial_word_loader: collects a serial frame into a parallel word.
// When the frame completes, it issues a one-cycle load enable for a
// downstream enabled register bank.
// Ports:
//   CLK, RST   clock; asynchronous active-high reset
//   SSTART     frame start / restart strobe
//   SIN        serial data bit, qualified by SVALID
//   SVALID     SIN is valid this cycle
//   PDATA      last completed word, held between loads
//   LOAD_E     one-cycle pulse while the FSM is in DONE
//   BUSY       high while a frame is being shifted in
//   FRAME_ERR  one-cycle pulse after a restart that discarded received bits
//   BITCNT     number of bits accepted in the current frame
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SSTART,
  input  logic                   SIN,
  input  logic                   SVALID,
  output logic [WIDTH-1:0]       PDATA,
  output logic                   LOAD_E,
  output logic                   BUSY,
  output logic                   FRAME_ERR,
  output logic [$clog2(WIDTH):0] BITCNT
);

  localparam int                 CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

  swl_state_t         r_state;
  swl_state_t         w_next;
  logic [WIDTH-1:0]   r_pdata;
  logic               r_frame_err;
  logic               w_clear;
  logic               w_shift;
  logic               w_load;
  logic               w_err;
  logic [WIDTH-1:0]   w_shifted;
  logic [CNT_W-1:0]   w_bitcnt;

  shift_counter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_counter (
    .CLK       (CLK),
    .RST       (RST),
    .i_clear   (w_clear),
    .i_shift   (w_shift),
    .i_sin     (SIN),
    .o_shifted (w_shifted),
    .o_bitcnt  (w_bitcnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_shift = 1'b0;
    w_load  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (SSTART) begin
          w_next  = ST_SHIFT;
          w_clear = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (SSTART) begin
          // Restart: drop the partial word. Only flag an error if bits were lost.
          w_clear = 1'b1;
          w_err   = (w_bitcnt != '0);
        end else if (SVALID) begin
          if (w_bitcnt == LAST_BIT) begin
            // Final bit: capture the word including this bit and rearm the counter.
            w_next  = ST_DONE;
            w_clear = 1'b1;
            w_load  = 1'b1;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (SSTART) begin
          w_next  = ST_SHIFT;
          w_clear = 1'b1;
        end else begin
          w_next  = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pdata     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_load) r_pdata <= w_shifted;
      r_frame_err <= w_err;
    end
  end

  // Outputs are decoded directly from registers, so LOAD_E is glitch-free
  // and can drive the enable input of downstream flops.
  assign PDATA     = r_pdata;
  assign LOAD_E    = (r_state == ST_DONE);
  assign BUSY      = (r_state == ST_SHIFT);
  assign FRAME_ERR = r_frame_err;
  assign BITCNT    = w_bitcnt;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed testbench for serial_word_loader.
// Two instances (MSB-first and LSB-first) share the same stimulus.
module tb_serial_word_loader;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SSTART;
  logic       SIN;
  logic       SVALID;
  logic [7:0] pdata_m, pdata_l;
  logic       load_m, load_l, busy_m, busy_l, ferr_m, ferr_l;
  logic [3:0] cnt_m, cnt_l;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int t0, t1;

  serial_word_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .RST(RST), .SSTART(SSTART), .SIN(SIN), .SVALID(SVALID),
    .PDATA(pdata_m), .LOAD_E(load_m), .BUSY(busy_m), .FRAME_ERR(ferr_m), .BITCNT(cnt_m)
  );

  serial_word_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .RST(RST), .SSTART(SSTART), .SIN(SIN), .SVALID(SVALID),
    .PDATA(pdata_l), .LOAD_E(load_l), .BUSY(busy_l), .FRAME_ERR(ferr_l), .BITCNT(cnt_l)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sends w[7]..w[0] on SVALID cycles; optional gaps of 1-3 idle cycles between bits.
  task automatic send_word(input logic [7:0] w, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      SSTART = 1'b0;
      SVALID = 1'b1;
      SIN    = w[i];
      tick();
      SVALID = 1'b0;
      SIN    = 1'b0;
      if (gaps && i > 0) begin
        for (int g = 0; g <= (i % 3); g++) begin
          tick();
          chk("gap_busy", {31'd0, busy_m}, 32'd1);
          chk("gap_load", {31'd0, load_m}, 32'd0);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1; SSTART = 1'b0; SIN = 1'b0; SVALID = 1'b0;
    #2;
    chk("rst_pdata",  {24'd0, pdata_m}, 32'h0);
    chk("rst_load",   {31'd0, load_m},  32'd0);
    chk("rst_busy",   {31'd0, busy_m},  32'd0);
    chk("rst_ferr",   {31'd0, ferr_m},  32'd0);
    chk("rst_bitcnt", {28'd0, cnt_m},   32'd0);
    tick();
    RST = 1'b0;

    // Idle ignores SVALID
    SVALID = 1'b1; SIN = 1'b1;
    tick();
    chk("idle_busy",   {31'd0, busy_m}, 32'd0);
    chk("idle_bitcnt", {28'd0, cnt_m},  32'd0);
    SVALID = 1'b0;

    // Frame A5, consecutive bits
    SSTART = 1'b1;
    tick();
    SSTART = 1'b0;
    chk("start_busy",   {31'd0, busy_m}, 32'd1);
    chk("start_bitcnt", {28'd0, cnt_m},  32'd0);
    for (int i = 7; i >= 1; i--) begin
      SVALID = 1'b1; SIN = 1'(8'hA5 >> i);
      tick();
    end
    chk("a5_bitcnt7", {28'd0, cnt_m},   32'd7);
    chk("a5_noload",  {31'd0, load_m},  32'd0);
    chk("a5_pd_hold", {24'd0, pdata_m}, 32'h0);
    SIN = 1'b1;
    tick();
    SVALID = 1'b0;
    chk("a5_load",    {31'd0, load_m},  32'd1);
    chk("a5_pdata",   {24'd0, pdata_m}, 32'hA5);
    chk("a5_lsb",     {24'd0, pdata_l}, 32'hA5);
    chk("a5_busy",    {31'd0, busy_m},  32'd0);
    chk("a5_bitcnt0", {28'd0, cnt_m},   32'd0);
    tick();
    chk("a5_load_end", {31'd0, load_m}, 32'd0);
    chk("a5_idle",     {31'd0, busy_m}, 32'd0);

    // Abort after 3 bits, then 5A completes
    SSTART = 1'b1;
    tick();
    SSTART = 1'b0;
    for (int i = 0; i < 3; i++) begin
      SVALID = 1'b1; SIN = 1'b1;
      tick();
    end
    chk("ab_bitcnt3", {28'd0, cnt_m}, 32'd3);
    SSTART = 1'b1; SVALID = 1'b1; SIN = 1'b1;
    tick();
    SSTART = 1'b0; SVALID = 1'b0;
    chk("ab_ferr",   {31'd0, ferr_m},  32'd1);
    chk("ab_bitcnt", {28'd0, cnt_m},   32'd0);
    chk("ab_busy",   {31'd0, busy_m},  32'd1);
    chk("ab_pdata",  {24'd0, pdata_m}, 32'hA5);
    tick();
    chk("ab_ferr_end", {31'd0, ferr_m}, 32'd0);
    // Restart with zero bits received is not an error
    SSTART = 1'b1;
    tick();
    SSTART = 1'b0;
    tick();
    chk("ab_restart0_ferr", {31'd0, ferr_m}, 32'd0);
    send_word(8'h5A, 1'b0);
    chk("5a_load",  {31'd0, load_m},  32'd1);
    chk("5a_pdata", {24'd0, pdata_m}, 32'h5A);
    chk("5a_lsb",   {24'd0, pdata_l}, 32'h5A);
    tick();

    // Back-to-back 3C then C3
    SSTART = 1'b1;
    tick();
    send_word(8'h3C, 1'b0);
    chk("3c_load",  {31'd0, load_m},  32'd1);
    chk("3c_pdata", {24'd0, pdata_m}, 32'h3C);
    t0 = cyc;
    SSTART = 1'b1;
    tick();
    SSTART = 1'b0;
    chk("b2b_busy",   {31'd0, busy_m},  32'd1);
    chk("b2b_noload", {31'd0, load_m},  32'd0);
    chk("b2b_hold",   {24'd0, pdata_m}, 32'h3C);
    send_word(8'hC3, 1'b0);
    t1 = cyc;
    chk("c3_load",  {31'd0, load_m},  32'd1);
    chk("c3_pdata", {24'd0, pdata_m}, 32'hC3);
    chk("c3_lsb",   {24'd0, pdata_l}, 32'hC3);
    chk("b2b_spacing", 32'(t1 - t0), 32'd9);
    tick();

    // A5 with gaps
    SSTART = 1'b1;
    tick();
    send_word(8'hA5, 1'b1);
    chk("gap_load1",  {31'd0, load_m},  32'd1);
    chk("gap_pdata",  {24'd0, pdata_m}, 32'hA5);
    chk("gap_lsb",    {24'd0, pdata_l}, 32'hA5);
    tick();
    chk("gap_load_end", {31'd0, load_m}, 32'd0);

    // Reset mid-frame after 5 bits
    SSTART = 1'b1;
    tick();
    SSTART = 1'b0;
    for (int i = 0; i < 5; i++) begin
      SVALID = 1'b1; SIN = 1'b1;
      tick();
    end
    SVALID = 1'b0;
    chk("mr_bitcnt5", {28'd0, cnt_m}, 32'd5);
    #2 RST = 1'b1;
    #1;
    chk("mr_pdata",  {24'd0, pdata_m}, 32'h0);
    chk("mr_busy",   {31'd0, busy_m},  32'd0);
    chk("mr_bitcnt", {28'd0, cnt_m},   32'd0);
    chk("mr_load",   {31'd0, load_m},  32'd0);
    chk("mr_ferr",   {31'd0, ferr_m},  32'd0);
    #2 RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      SVALID = 1'b1; SIN = 1'b1;
      tick();
      chk("mr_noload", {31'd0, load_m}, 32'd0);
    end
    SVALID = 1'b0;
    // First SSTART after reset honoured on the next edge
    RST = 1'b1;
    #1 RST = 1'b0;
    SSTART = 1'b1;
    tick();
    SSTART = 1'b0;
    chk("mr_start_busy", {31'd0, busy_m}, 32'd1);
    send_word(8'h3C, 1'b0);
    chk("mr_fresh_load",  {31'd0, load_m},  32'd1);
    chk("mr_fresh_pdata", {24'd0, pdata_m}, 32'h3C);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
